// File: rtl/c1541_track_ctrl.sv
// c1541_track_ctrl: head positioning and track-buffer sequencer for the 1541 drive model.
// Decodes the UC3 stepper phases into a half-track position, drives the track-0 sensor,
// and after the head has settled writes back a dirty buffer and loads the new track
// through a req/ack/done handshake with the SD image loader.
`timescale 1ns/1ps
module c1541_track_ctrl #(
  parameter int MAX_HTRACK   = 83,
  parameter int RESET_HTRACK = 36,
  parameter int SETTLE_CYC   = 640000
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic [1:0] stp,
  input  logic       mtr,
  input  logic       mode,
  input  logic       wr_byte,
  input  logic       img_mounted,
  input  logic       img_valid,
  input  logic       sd_ack,
  input  logic       sd_done,
  output logic       ld_req,
  output logic       sv_req,
  output logic [5:0] req_track,
  output logic [6:0] half_track,
  output logic       tr00_sense_n,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAVE_REQ,
    S_SAVE_WAIT,
    S_LOAD_REQ,
    S_LOAD_WAIT
  } state_e;

  localparam int             CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [6:0]     MAX_HT      = 7'(MAX_HTRACK);
  localparam logic [6:0]     RESET_HT    = 7'(RESET_HTRACK);
  localparam logic [5:0]     TRK_INVALID = 6'd63;

  state_e           state_q, state_d;
  logic [1:0]       ph_q;
  logic [6:0]       ht_q, ht_d;
  logic             tr00_n_q;
  logic             img_valid_q;
  logic             step;
  logic [5:0]       tgt_trk;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       loaded_q, loaded_d;
  logic [5:0]       ld_trk_q, ld_trk_d;
  logic             dirty_q, dirty_d;
  logic             stale_q, stale_d;
  logic             ld_req_q, ld_req_d;
  logic             sv_req_q, sv_req_d;
  logic [5:0]       req_trk_q, req_trk_d;

  // Stepper phase history: tracks stp every cycle, including while reset is held.
  // NOTE: deliberately not reset, so it holds the live stp sample when reset releases
  // and the first phase change afterwards is decoded relative to the real coil state.
  always_ff @(posedge clk32) begin
    ph_q <= stp;
  end

  // Head motion: one phase forward steps in, one phase back steps out, two is ambiguous.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ht_d = ht_q;
    if (mtr) begin
      if (stp == ph_q + 2'd1) begin
        if (ht_q < MAX_HT) ht_d = ht_q + 7'd1;
      end else if (stp == ph_q - 2'd1) begin
        if (ht_q != 7'd0) ht_d = ht_q - 7'd1;
      end
    end
  end

  assign step    = (ht_d != ht_q);
  assign tgt_trk = ht_q[6:1];

  // State register and all sequential datapath state.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ht_q        <= RESET_HT;
      tr00_n_q    <= 1'b1;
      img_valid_q <= 1'b0;
      cnt_q       <= '0;
      loaded_q    <= TRK_INVALID;
      ld_trk_q    <= 6'd0;
      dirty_q     <= 1'b0;
      stale_q     <= 1'b0;
      ld_req_q    <= 1'b0;
      sv_req_q    <= 1'b0;
      req_trk_q   <= 6'd0;
    end else begin
      state_q     <= state_d;
      ht_q        <= ht_d;
      tr00_n_q    <= (ht_q != 7'd0);
      img_valid_q <= img_valid;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      ld_trk_q    <= ld_trk_d;
      dirty_q     <= dirty_d;
      stale_q     <= stale_d;
      ld_req_q    <= ld_req_d;
      sv_req_q    <= sv_req_d;
      req_trk_q   <= req_trk_d;
    end
  end

  // Next-state logic: settle after motion, optional write-back, then load.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (img_valid && (tgt_trk != loaded_q)) state_d = S_SETTLE;
      S_SETTLE:
        if (!img_valid) state_d = S_IDLE;
        else if (!step && (cnt_q == CNT_LAST))
          state_d = (dirty_q && (loaded_q != TRK_INVALID)) ? S_SAVE_REQ : S_LOAD_REQ;
      S_SAVE_REQ:
        if (img_mounted) state_d = S_IDLE;
        else if (sd_ack) state_d = S_SAVE_WAIT;
      S_SAVE_WAIT:
        if (sd_done) state_d = S_LOAD_REQ;
      S_LOAD_REQ:
        if (sd_ack) state_d = S_LOAD_WAIT;
      S_LOAD_WAIT:
        if (sd_done) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic: settle counter, buffer bookkeeping, registered requests.
  always_comb begin
    cnt_d     = cnt_q;
    loaded_d  = loaded_q;
    ld_trk_d  = ld_trk_q;
    dirty_d   = dirty_q;
    req_trk_d = req_trk_q;
    ld_req_d  = (state_d == S_LOAD_REQ);
    sv_req_d  = (state_d == S_SAVE_REQ);
    // A mount while a load is in flight makes the arriving data belong to the old image.
    stale_d   = (state_d == S_LOAD_WAIT) && (stale_q || img_mounted);

    unique case (state_q)
      S_IDLE: cnt_d = '0;
      S_SETTLE: begin
        if (step) cnt_d = '0;
        else if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
        if (state_d == S_LOAD_REQ) ld_trk_d = tgt_trk;
      end
      S_SAVE_WAIT:
        if (sd_done) begin
          dirty_d  = 1'b0;
          ld_trk_d = tgt_trk;
        end
      S_LOAD_WAIT:
        if (sd_done) loaded_d = stale_q ? TRK_INVALID : ld_trk_q;
      default: ;
    endcase

    if ((state_q == S_IDLE) && wr_byte && !mode) dirty_d = 1'b1;

    // A new image invalidates the buffer and discards pending writes.
    if (img_mounted) begin
      loaded_d = TRK_INVALID;
      dirty_d  = 1'b0;
    end

    if (state_d == S_SAVE_REQ)      req_trk_d = loaded_q;
    else if (state_d == S_LOAD_REQ) req_trk_d = ld_trk_d;
  end

  assign ld_req       = ld_req_q;
  assign sv_req       = sv_req_q;
  assign req_track    = req_trk_q;
  assign half_track   = ht_q;
  assign tr00_sense_n = tr00_n_q;
  assign busy         = (state_q != S_IDLE) | (loaded_q != tgt_trk) | ~img_valid_q;

endmodule
